// File: rtl/pixpack_pkg.sv
// Shared types and helpers for the pixel packer and its AXI4-Stream output register.
package pixpack_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int PIX_W_DEF  = 8;
    localparam int LANES      = DATA_W_DEF / PIX_W_DEF;
    localparam int STRB_W     = DATA_W_DEF / 8;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } pack_state_t;

    // Byte-lane strobe for a beat carrying nlanes pixels, low lanes first.
    function automatic logic [63:0] lanes_to_strb(input int nlanes, input int pix_w = PIX_W_DEF);
        logic [63:0] one;
        one = 64'd1;
        return (one << (nlanes * pix_w / 8)) - 64'd1;
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXI4-Stream output register: loads a beat when empty or draining,
// holds tdata/tstrb/tlast stable until the downstream handshake.
module axis_out_reg
    import pixpack_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int STRB_W_P = DATA_W / 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [DATA_W-1:0]   load_data,
    input  logic [STRB_W_P-1:0] load_strb,
    input  logic                load_last,
    output logic                can_load,
    output logic                tvalid,
    output logic [DATA_W-1:0]   tdata,
    output logic [STRB_W_P-1:0] tstrb,
    output logic                tlast,
    input  logic                tready
);

    assign can_load = ~tvalid | tready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tvalid <= 1'b0;
            tdata  <= '0;
            tstrb  <= '0;
            tlast  <= 1'b0;
        end else if (load) begin
            tvalid <= 1'b1;
            tdata  <= load_data;
            tstrb  <= load_strb;
            tlast  <= load_last;
        end else if (tready) begin
            tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_pixel_packer.sv
// Packs one pixel per cycle into DATA_W-wide AXI4-Stream beats, one row per packet.
// Optional macro AXIS_TLAST_AUTO_EN: close packets every ROW_LEN pixels instead of on pix_last.
module axis_pixel_packer
    import pixpack_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int PIX_W   = PIX_W_DEF,
    parameter int ROW_LEN = 32
) (
    input  logic                  m_axis_aclk,
    input  logic                  m_axis_areset,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    input  logic [PIX_W-1:0]      pix_data,
    input  logic                  pix_last,
    output logic                  m_axis_tvalid,
    output logic [DATA_W-1:0]     m_axis_tdata,
    output logic [DATA_W/8-1:0]   m_axis_tstrb,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [15:0]           row_count,
    output logic                  busy
);

    localparam int NLANES = DATA_W / PIX_W;
    localparam int NSTRB  = DATA_W / 8;
    localparam int CNT_W  = (NLANES > 1) ? $clog2(NLANES) : 1;

    pack_state_t       state, state_next;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] asm_data, beat_data, load_data;
    logic [NSTRB-1:0]  beat_strb, hold_strb, load_strb;
    logic              hold_last, load_last;
    logic              row_end, accept, close_beat, can_load, load;

`ifdef AXIS_TLAST_AUTO_EN
    localparam int PC_W = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
    logic [PC_W-1:0] pix_cnt;
    logic            unused_pix_last;

    assign unused_pix_last = pix_last;
    assign row_end = (pix_cnt == PC_W'(ROW_LEN - 1));

    always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
        if (m_axis_areset) begin
            pix_cnt <= '0;
        end else if (accept) begin
            pix_cnt <= row_end ? '0 : pix_cnt + 1'b1;
        end
    end
`else
    localparam int unused_row_len = ROW_LEN;
    assign row_end = pix_last;
`endif

    // The beat as it would look with the current pixel written into its lane.
    always_comb begin
        beat_data = asm_data;
        beat_data[int'(cnt) * PIX_W +: PIX_W] = pix_data;
        beat_strb = NSTRB'(lanes_to_strb(int'(cnt) + 1, PIX_W));
        accept = pix_valid & pix_ready;
        close_beat = accept & ((cnt == CNT_W'(NLANES - 1)) | row_end);
    end

    always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
        if (m_axis_areset) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FILL: if (close_beat && !can_load) state_next = HOLD;
            HOLD: if (can_load) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    always_comb begin
        pix_ready = (state == FILL) & ~m_axis_areset;
        load      = 1'b0;
        load_data = beat_data;
        load_strb = beat_strb;
        load_last = row_end;
        if (state == HOLD) begin
            load      = can_load;
            load_data = asm_data;
            load_strb = hold_strb;
            load_last = hold_last;
        end else begin
            load = close_beat & can_load;
        end
    end

    // A blocked beat parks in the assembly register until the output drains.
    always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
        if (m_axis_areset) begin
            asm_data  <= '0;
            cnt       <= '0;
            hold_strb <= '0;
            hold_last <= 1'b0;
        end else if (state == FILL && accept) begin
            if (close_beat) begin
                cnt <= '0;
                if (can_load) begin
                    asm_data <= '0;
                end else begin
                    asm_data  <= beat_data;
                    hold_strb <= beat_strb;
                    hold_last <= row_end;
                end
            end else begin
                asm_data <= beat_data;
                cnt      <= cnt + 1'b1;
            end
        end else if (state == HOLD && can_load) begin
            asm_data <= '0;
        end
    end

    always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
        if (m_axis_areset) begin
            row_count <= '0;
        end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            row_count <= row_count + 16'd1;
        end
    end

    assign busy = (cnt != '0) | (state == HOLD) | m_axis_tvalid;

    axis_out_reg #(
        .DATA_W   (DATA_W),
        .STRB_W_P (NSTRB)
    ) u_out_reg (
        .clk       (m_axis_aclk),
        .rst       (m_axis_areset),
        .load      (load),
        .load_data (load_data),
        .load_strb (load_strb),
        .load_last (load_last),
        .can_load  (can_load),
        .tvalid    (m_axis_tvalid),
        .tdata     (m_axis_tdata),
        .tstrb     (m_axis_tstrb),
        .tlast     (m_axis_tlast),
        .tready    (m_axis_tready)
    );

endmodule

// File: tb/tb_axis_pixel_packer.sv
// Directed bench for axis_pixel_packer: vector table plus stall, toggle and reset sequences,
// with a reference packer scoreboarding every output beat. Honors AXIS_TLAST_AUTO_EN.
module tb_axis_pixel_packer;

`ifdef AXIS_TLAST_AUTO_EN
    localparam int ROW_LEN = 6;
`else
    localparam int ROW_LEN = 32;
`endif

    logic        clk;
    logic        rst;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  pix_data;
    logic        pix_last;
    logic        tvalid;
    logic [31:0] tdata;
    logic [3:0]  tstrb;
    logic        tlast;
    logic        tready;
    logic [15:0] row_count;
    logic        busy;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  s;
        logic        l;
    } beat_t;

    typedef struct {
        logic [7:0]  pix;
        logic        last;
        logic        exp_v;
        logic [31:0] exp_d;
        logic [3:0]  exp_s;
        logic        exp_l;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    beat_t       exp_q[$];
    int          mdl_lane   = 0;
    int          mdl_pixcnt = 0;
    logic [31:0] mdl_data   = '0;
    logic        hold_pending = 1'b0;
    beat_t       held_beat;

    vec_t vecs[16];
    int   nvec;

    axis_pixel_packer #(
        .DATA_W  (32),
        .PIX_W   (8),
        .ROW_LEN (ROW_LEN)
    ) dut (
        .m_axis_aclk   (clk),
        .m_axis_areset (rst),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .pix_data      (pix_data),
        .pix_last      (pix_last),
        .m_axis_tvalid (tvalid),
        .m_axis_tdata  (tdata),
        .m_axis_tstrb  (tstrb),
        .m_axis_tlast  (tlast),
        .m_axis_tready (tready),
        .row_count     (row_count),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Offer one pixel starting at a falling edge; return at the falling edge after it is taken.
    task automatic applyStimulus(input logic [7:0] d, input logic l);
        logic accepted;
        accepted  = 1'b0;
        pix_valid = 1'b1;
        pix_data  = d;
        pix_last  = l;
        for (int i = 0; i < 200 && !accepted; i++) begin
            #4;
            accepted = pix_ready;
            @(negedge clk);
        end
        checkOutput("pix_accept", 64'(accepted), 64'd1);
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 500 && busy; i++) @(negedge clk);
        checkOutput("idle", 64'(busy), 64'd0);
    endtask

    // Reference packer and beat scoreboard, sampled just before each rising edge.
    initial begin : monitor
        logic  close;
        logic  endrow;
        beat_t b;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                exp_q.delete();
                mdl_lane     = 0;
                mdl_pixcnt   = 0;
                mdl_data     = '0;
                hold_pending = 1'b0;
            end else begin
                if (hold_pending && tvalid)
                    checkOutput("stable_beat", 64'({tdata, tstrb, tlast}), 64'(held_beat));
                if (tvalid && tready) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("sb_nonempty", 64'(exp_q.size()), 64'd1);
                    end else begin
                        b = exp_q.pop_front();
                        checkOutput("beat", 64'({tdata, tstrb, tlast}), 64'(b));
                    end
                    hold_pending = 1'b0;
                end else if (tvalid) begin
                    held_beat    = {tdata, tstrb, tlast};
                    hold_pending = 1'b1;
                end
                if (pix_valid && pix_ready) begin
                    mdl_data[mdl_lane*8 +: 8] = pix_data;
`ifdef AXIS_TLAST_AUTO_EN
                    endrow = (mdl_pixcnt == ROW_LEN - 1);
                    mdl_pixcnt = endrow ? 0 : mdl_pixcnt + 1;
`else
                    endrow = pix_last;
`endif
                    close = (mdl_lane == 3) || endrow;
                    if (close) begin
                        exp_q.push_back({mdl_data, 4'((1 << (mdl_lane + 1)) - 1), endrow});
                        mdl_data = '0;
                        mdl_lane = 0;
                    end else begin
                        mdl_lane++;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation hung");
    end

    initial begin : main
`ifdef AXIS_TLAST_AUTO_EN
        vecs[0]  = '{8'h90, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
        vecs[1]  = '{8'h91, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
        vecs[2]  = '{8'h92, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
        vecs[3]  = '{8'h93, 1'b0, 1'b1, 32'h93929190, 4'hF, 1'b0};
        vecs[4]  = '{8'h94, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
        vecs[5]  = '{8'h95, 1'b0, 1'b1, 32'h00009594, 4'h3, 1'b1};
        vecs[6]  = '{8'h96, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
        vecs[7]  = '{8'h97, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
        vecs[8]  = '{8'h98, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
        vecs[9]  = '{8'h99, 1'b0, 1'b1, 32'h99989796, 4'hF, 1'b0};
        vecs[10] = '{8'h9A, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
        vecs[11] = '{8'h9B, 1'b0, 1'b1, 32'h00009B9A, 4'h3, 1'b1};
        nvec = 12;
`else
        vecs[0]  = '{8'h01, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
        vecs[1]  = '{8'h02, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
        vecs[2]  = '{8'h03, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
        vecs[3]  = '{8'h04, 1'b0, 1'b1, 32'h04030201, 4'hF, 1'b0};
        vecs[4]  = '{8'h05, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
        vecs[5]  = '{8'h06, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
        vecs[6]  = '{8'h07, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
        vecs[7]  = '{8'h08, 1'b1, 1'b1, 32'h08070605, 4'hF, 1'b1};
        vecs[8]  = '{8'hA0, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
        vecs[9]  = '{8'hA1, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
        vecs[10] = '{8'hA2, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
        vecs[11] = '{8'hA3, 1'b0, 1'b1, 32'hA3A2A1A0, 4'hF, 1'b0};
        vecs[12] = '{8'hA4, 1'b1, 1'b1, 32'h000000A4, 4'h1, 1'b1};
        nvec = 13;
`endif
        rst       = 1'b1;
        pix_valid = 1'b0;
        pix_data  = '0;
        pix_last  = 1'b0;
        tready    = 1'b1;

        repeat (3) @(negedge clk);
        checkOutput("rst_tvalid",    64'(tvalid),    64'd0);
        checkOutput("rst_tdata",     64'(tdata),     64'd0);
        checkOutput("rst_tstrb",     64'(tstrb),     64'd0);
        checkOutput("rst_tlast",     64'(tlast),     64'd0);
        checkOutput("rst_row_count", 64'(row_count), 64'd0);
        checkOutput("rst_busy",      64'(busy),      64'd0);
        checkOutput("rst_pix_ready", 64'(pix_ready), 64'd0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_pix_ready", 64'(pix_ready), 64'd1);
        @(negedge clk);

        // Back-to-back rows with tready held high.
        for (int i = 0; i < nvec; i++) begin
            applyStimulus(vecs[i].pix, vecs[i].last);
            checkOutput("vec_tvalid", 64'(tvalid), 64'(vecs[i].exp_v));
            if (vecs[i].exp_v) begin
                checkOutput("vec_tdata", 64'(tdata), 64'(vecs[i].exp_d));
                checkOutput("vec_tstrb", 64'(tstrb), 64'(vecs[i].exp_s));
                checkOutput("vec_tlast", 64'(tlast), 64'(vecs[i].exp_l));
            end
        end
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        waitIdle();
        checkOutput("row_count_table", 64'(row_count), 64'd2);
        checkOutput("sb_empty_table", 64'(exp_q.size()), 64'd0);

`ifndef AXIS_TLAST_AUTO_EN
        // Long downstream stall mid-row: the second beat must park in HOLD.
        tready = 1'b0;
        for (int i = 0; i < 8; i++) applyStimulus(8'(8'h30 + i), 1'b0);
        pix_valid = 1'b0;
        checkOutput("hold_pix_ready", 64'(pix_ready), 64'd0);
        checkOutput("hold_tdata", 64'(tdata), 64'h33323130);
        repeat (12) @(negedge clk);
        checkOutput("stall_pix_ready", 64'(pix_ready), 64'd0);
        checkOutput("stall_busy", 64'(busy), 64'd1);
        checkOutput("stall_tdata", 64'(tdata), 64'h33323130);
        tready = 1'b1;
        for (int i = 8; i < 12; i++) applyStimulus(8'(8'h30 + i), (i == 11));
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        waitIdle();
        checkOutput("row_count_stall", 64'(row_count), 64'd3);
        checkOutput("sb_empty_stall", 64'(exp_q.size()), 64'd0);

        // tready toggling against a continuous stream.
        fork
            begin
                repeat (40) begin
                    @(negedge clk);
                    tready = ~tready;
                end
                tready = 1'b1;
            end
            begin
                for (int i = 0; i < 16; i++) applyStimulus(8'(8'h50 + i), (i == 15));
                pix_valid = 1'b0;
                pix_last  = 1'b0;
            end
        join
        waitIdle();
        checkOutput("row_count_toggle", 64'(row_count), 64'd4);
        checkOutput("sb_empty_toggle", 64'(exp_q.size()), 64'd0);

        // Reset with a pending beat and a partial beat in flight.
        tready = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(8'(8'h60 + i), 1'b0);
        applyStimulus(8'h70, 1'b0);
        applyStimulus(8'h71, 1'b0);
        pix_valid = 1'b0;
        checkOutput("pre_rst_tvalid", 64'(tvalid), 64'd1);
        checkOutput("pre_rst_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        checkOutput("midrow_rst_tvalid", 64'(tvalid), 64'd0);
        checkOutput("midrow_rst_busy", 64'(busy), 64'd0);
        checkOutput("midrow_rst_row_count", 64'(row_count), 64'd0);
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        tready = 1'b1;
        @(negedge clk);
        applyStimulus(8'h80, 1'b0);
        applyStimulus(8'h81, 1'b0);
        applyStimulus(8'h82, 1'b1);
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        checkOutput("after_rst_tdata", 64'(tdata), 64'h00828180);
        checkOutput("after_rst_tstrb", 64'(tstrb), 64'h7);
        checkOutput("after_rst_tlast", 64'(tlast), 64'd1);
        waitIdle();
        checkOutput("row_count_after_rst", 64'(row_count), 64'd1);
        checkOutput("sb_empty_rst", 64'(exp_q.size()), 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
